note_sequencer: RTL and testbench

//   Steps through the 64-word x 32-bit note RAM at the tempo set by clock_devider.

---
 rtl/note_sequencer_if.sv | 23 ++
 rtl/note_sequencer.sv | 133 +++++++++++++
 tb/tb_note_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/note_sequencer_if.sv
// Bus between the note sequencer, the note RAM read port and the datapath.
// The master side is the sequencer. The slave side is the RAM plus the datapath.
interface note_sequencer_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) ();
  logic              ram_rden;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_q;
  logic              note_valid;
  logic [DATA_W-1:0] note_data;
  logic              note_ready;

  modport master (
    output ram_rden, ram_addr, note_valid, note_data,
    input  ram_q, note_ready
  );

  modport slave (
    input  ram_rden, ram_addr, note_valid, note_data,
    output ram_q, note_ready
  );
endinterface

// File: rtl/note_sequencer.sv
// Walks the note RAM one word per tempo tick and hands each word to the datapath.
// Ticks that arrive while a note is still in flight are remembered once, then counted as overruns.
module note_sequencer #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int OVR_W  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              pause,
  input  logic              loop,
  input  logic [ADDR_W:0]   song_len,
  input  logic              tick,
  note_sequencer_if.master  bus,
  output logic              busy,
  output logic              done,
  output logic [OVR_W-1:0]  overrun
);

  localparam int IDX_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0] LEN_MAX = IDX_W'(2 ** ADDR_W);
  localparam logic [IDX_W:0]   ONE     = (IDX_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PRESENT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                pending_q, pending_d;
  logic [OVR_W-1:0]    overrun_q, overrun_d;
  logic [DATA_W-1:0]   note_data_q, note_data_d;

  logic [IDX_W-1:0]    len_eff;
  logic [IDX_W:0]      idx_inc;
  logic                last_note;
  logic                tick_defer;
  logic                advance;

  always_comb begin
    len_eff    = (song_len > LEN_MAX) ? LEN_MAX : song_len;
    idx_inc    = {1'b0, idx_q} + ONE;
    // A shrunken song_len can leave idx beyond the end; that still counts as the last note.
    last_note  = (idx_inc >= {1'b0, len_eff});
    tick_defer = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                 (state_q == S_PRESENT) || ((state_q == S_HOLD) && pause);
    advance    = (state_q == S_HOLD) && (tick || pending_q) && !pause;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    note_data_d = note_data_q;

    if (tick && tick_defer) begin
      if (!pending_q) begin
        pending_d = 1'b1;
      end else if (overrun_q != {OVR_W{1'b1}}) begin
        overrun_d = overrun_q + OVR_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pending_d = 1'b0;
          overrun_d = '0;
          idx_d     = '0;
          state_d   = (len_eff == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH:   state_d = S_WAIT;
      S_WAIT: begin
        note_data_d = bus.ram_q;
        state_d     = S_PRESENT;
      end
      S_PRESENT: begin
        if (bus.note_ready) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (advance) begin
          pending_d = 1'b0;
          if (!last_note) begin
            idx_d   = idx_inc[IDX_W-1:0];
            state_d = S_FETCH;
          end else if (loop) begin
            idx_d   = '0;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      pending_q   <= 1'b0;
      overrun_q   <= '0;
      note_data_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      note_data_q <= note_data_d;
    end
  end

  assign bus.ram_rden   = (state_q == S_FETCH);
  assign bus.ram_addr   = idx_q[ADDR_W-1:0];
  assign bus.note_valid = (state_q == S_PRESENT);
  assign bus.note_data  = note_data_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a table of songs plus hand-written corner sequences.
// A scoreboard queues expected read addresses and note words, and a negedge monitor pops them.
module tb_note_sequencer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       loop = 1'b0;
  logic       tick = 1'b0;
  logic [6:0] song_len = 7'd0;
  logic       busy;
  logic       done;
  logic [7:0] overrun;

  note_sequencer_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  always #5 clk = ~clk;

  note_sequencer #(.ADDR_W(6), .DATA_W(32), .OVR_W(8)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .pause    (pause),
    .loop     (loop),
    .song_len (song_len),
    .tick     (tick),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun)
  );

  logic [31:0] mem [64];

  always @(posedge clk) begin
    if (bus.ram_rden) bus.ram_q <= mem[bus.ram_addr];
  end

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int rden_cnt = 0;
  logic done_prev = 1'b0;
  logic [5:0]  exp_addr [$];
  logic [31:0] exp_data [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (bus.ram_rden === 1'b1) begin
        rden_cnt++;
        if (exp_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL read_extra: got read of addr %0d expected no read", bus.ram_addr);
        end else begin
          chk("read_addr", {26'd0, bus.ram_addr}, {26'd0, exp_addr.pop_front()});
        end
      end
      if (bus.note_valid === 1'b1 && bus.note_ready === 1'b1) begin
        hs_cnt++;
        $display("note handshake %0d data %08h", hs_cnt, bus.note_data);
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL note_extra: got note %08h expected no note", bus.note_data);
        end else begin
          chk("note_data", bus.note_data, exp_data.pop_front());
        end
      end
      if (done === 1'b1 && done_prev === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL done_width: got done high 2 cycles expected 1");
      end
      if (done === 1'b1) done_cnt++;
      done_prev = done;
    end else begin
      done_prev = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  task automatic push_song(input int len, input int notes);
    int leff;
    leff = (len > 64) ? 64 : len;
    for (int k = 0; k < notes; k++) begin
      exp_addr.push_back(6'(k % leff));
      exp_data.push_back(mem[k % leff]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},      {31'd0, busy}, 32'd0);
    chk({tag, "_done"},      {31'd0, done}, 32'd0);
    chk({tag, "_rden"},      {31'd0, bus.ram_rden}, 32'd0);
    chk({tag, "_valid"},     {31'd0, bus.note_valid}, 32'd0);
    chk({tag, "_addr"},      {26'd0, bus.ram_addr}, 32'd0);
    chk({tag, "_note_data"}, bus.note_data, 32'd0);
    chk({tag, "_overrun"},   {24'd0, overrun}, 32'd0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    exp_addr.delete();
    exp_data.delete();
  endtask

  typedef struct {
    int len;
    bit lp;
    int ticks;
    int gap;
    int exp_hs;
    int exp_done;
    bit exp_busy;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int r0;
    bit stable;
    logic [31:0] held;

    vecs[0] = '{3,  1'b0, 3,  10, 3,  1, 1'b0};
    vecs[1] = '{2,  1'b1, 5,  10, 6,  0, 1'b1};
    vecs[2] = '{1,  1'b0, 1,  8,  1,  1, 1'b0};
    vecs[3] = '{1,  1'b1, 3,  8,  4,  0, 1'b1};
    vecs[4] = '{70, 1'b0, 64, 6,  64, 1, 1'b0};
    vecs[5] = '{64, 1'b0, 64, 5,  64, 1, 1'b0};
    vecs[6] = '{0,  1'b0, 0,  5,  0,  1, 1'b0};

    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    bus.note_ready = 1'b0;

    step(2);
    check_reset_outputs("reset");
    resetn = 1'b1;
    step(1);

    for (int v = 0; v < 7; v++) begin
      song_len = 7'(vecs[v].len);
      loop = vecs[v].lp;
      bus.note_ready = 1'b1;
      hs_cnt = 0;
      done_cnt = 0;
      push_song(vecs[v].len, vecs[v].exp_hs);
      pulse_start();
      for (int t = 0; t < vecs[v].ticks; t++) begin
        step(vecs[v].gap - 1);
        pulse_tick();
      end
      step(12);
      $display("vector %0d len %0d loop %0d: handshakes %0d done %0d", v, vecs[v].len,
               vecs[v].lp, hs_cnt, done_cnt);
      chk($sformatf("v%0d_handshakes", v), hs_cnt, vecs[v].exp_hs);
      chk($sformatf("v%0d_done_pulses", v), done_cnt, vecs[v].exp_done);
      chk($sformatf("v%0d_busy", v), {31'd0, busy}, {31'd0, vecs[v].exp_busy});
      chk($sformatf("v%0d_overrun", v), {24'd0, overrun}, 32'd0);
      chk($sformatf("v%0d_pending_reads", v), exp_addr.size(), 0);
      if (vecs[v].exp_busy) begin
        do_reset();
        check_reset_outputs($sformatf("v%0d_after_reset", v));
      end
    end

    // Datapath stalls for 20 cycles, two ticks and a stray start arrive meanwhile.
    song_len = 7'd3;
    loop = 1'b0;
    bus.note_ready = 1'b0;
    hs_cnt = 0;
    done_cnt = 0;
    push_song(3, 3);
    pulse_start();
    w = 0;
    while (bus.note_valid !== 1'b1 && w < 10) begin
      step(1);
      w++;
    end
    chk("stall_valid_latency", w, 2);
    chk("stall_first_data", bus.note_data, mem[0]);
    held = bus.note_data;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5 || i == 12) tick = 1'b1;
      if (i == 8) start = 1'b1;
      step(1);
      tick = 1'b0;
      start = 1'b0;
      if (bus.note_data !== held || bus.note_valid !== 1'b1) stable = 1'b0;
    end
    $display("stall: 20 cycles held, overrun %0d", overrun);
    chk("stall_data_stable", {31'd0, stable}, 32'd1);
    chk("stall_overrun", {24'd0, overrun}, 32'd1);
    bus.note_ready = 1'b1;
    step(1);
    chk("stall_hold_valid", {31'd0, bus.note_valid}, 32'd0);
    step(1);
    chk("stall_pending_fetch", {31'd0, bus.ram_rden}, 32'd1);
    chk("stall_pending_addr", {26'd0, bus.ram_addr}, 32'd1);
    step(8);
    pulse_tick();
    step(8);
    pulse_tick();
    step(8);
    chk("stall_handshakes", hs_cnt, 3);
    chk("stall_done", done_cnt, 1);
    chk("stall_busy_end", {31'd0, busy}, 32'd0);
    chk("stall_overrun_kept", {24'd0, overrun}, 32'd1);

    // Pause in HOLD with three ticks, then release.
    song_len = 7'd4;
    hs_cnt = 0;
    done_cnt = 0;
    push_song(4, 4);
    pulse_start();
    chk("pause_overrun_cleared", {24'd0, overrun}, 32'd0);
    step(5);
    pause = 1'b1;
    r0 = rden_cnt;
    pulse_tick();
    step(2);
    pulse_tick();
    step(2);
    pulse_tick();
    step(2);
    $display("pause: three ticks, overrun %0d", overrun);
    chk("pause_overrun", {24'd0, overrun}, 32'd2);
    chk("pause_no_read", rden_cnt - r0, 0);
    chk("pause_busy", {31'd0, busy}, 32'd1);
    pause = 1'b0;
    step(1);
    chk("pause_release_fetch", {31'd0, bus.ram_rden}, 32'd1);
    chk("pause_release_addr", {26'd0, bus.ram_addr}, 32'd1);
    for (int t = 0; t < 3; t++) begin
      step(6);
      pulse_tick();
    end
    step(8);
    chk("pause_handshakes", hs_cnt, 4);
    chk("pause_done", done_cnt, 1);
    chk("pause_overrun_end", {24'd0, overrun}, 32'd2);

    // Reset while waiting on the RAM, then restart from address 0.
    song_len = 7'd3;
    exp_addr.push_back(6'd0);
    pulse_start();
    step(1);
    resetn = 1'b0;
    step(1);
    check_reset_outputs("wait_reset");
    resetn = 1'b1;
    chk("wait_reset_queue", exp_addr.size(), 0);
    song_len = 7'd1;
    hs_cnt = 0;
    done_cnt = 0;
    push_song(1, 1);
    pulse_start();
    chk("restart_fetch", {31'd0, bus.ram_rden}, 32'd1);
    chk("restart_addr", {26'd0, bus.ram_addr}, 32'd0);
    step(4);
    pulse_tick();
    step(6);
    chk("restart_handshakes", hs_cnt, 1);
    chk("restart_done", done_cnt, 1);

    // Empty song: done one cycle after start, no RAM traffic.
    song_len = 7'd0;
    r0 = rden_cnt;
    pulse_start();
    chk("empty_done", {31'd0, done}, 32'd1);
    chk("empty_busy", {31'd0, busy}, 32'd1);
    step(1);
    chk("empty_done_gone", {31'd0, done}, 32'd0);
    chk("empty_idle", {31'd0, busy}, 32'd0);
    chk("empty_no_read", rden_cnt - r0, 0);

    step(2);
    chk("final_addr_queue", exp_addr.size(), 0);
    chk("final_data_queue", exp_data.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
